// File: rtl/dino_pkg.sv
// Constants and state encodings shared by the motion controller, the sprite
// renderer and the cactus block, so all of them agree on the ground line.
package dino_pkg;

   localparam int GROUND   = 335;
   localparam int DINO_H   = 60;
   localparam int DINO_W   = 44;
   localparam int DINO_X   = 40;
   localparam int JUMP_V   = 12;
   localparam int GRAVITY  = 1;
   localparam int MAX_FALL = 12;

   localparam int Y_W = 10;
   localparam int V_W = 6;

   localparam logic [Y_W-1:0] REST_Y = 10'(GROUND - DINO_H);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      RISE = 2'd1,
      FALL = 2'd2,
      DUCK = 2'd3
   } dino_state_t;

   // Next fall speed: accelerate by GRAVITY, clamp at MAX_FALL.
   function automatic logic [V_W-1:0] fall_speed(input logic [V_W-1:0] vel);
      logic [V_W:0] v;
      v = {1'b0, vel} + 7'(GRAVITY);
      return (v > 7'(MAX_FALL)) ? 6'(MAX_FALL) : v[V_W-1:0];
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level; optionally also flags the
// first clock after the level rises.
module sync_edge #(
   parameter bit EDGE_EN = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic sync,
   output logic rise
);

   logic q1_reg;
   logic q2_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q1_reg <= 1'b0;
         q2_reg <= 1'b0;
      end else begin
         q1_reg <= d;
         q2_reg <= q1_reg;
      end
   end

   assign sync = q2_reg;

   generate
      if (EDGE_EN) begin : g_edge
         assign rise = q1_reg & ~q2_reg;
      end else begin : g_no_edge
         assign rise = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/dino_motion_ctrl.sv
// Jump/duck state machine and vertical position datapath for the dino sprite.
// Position only moves on the frame tick so coordinates are stable during video.
module dino_motion_ctrl
   import dino_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        screen_end,
   input  logic        up,
   input  logic        down,
   input  logic        freeze,
   output logic        frame_tick,
   output logic [31:0] dino_x,
   output logic [31:0] dino_y,
   output logic        airborne,
   output logic        ducking
);

   logic [2:0] raw_vec;
   logic [2:0] sync_vec;
   logic [2:0] rise_vec;
   logic       up_s;
   logic       down_s;

   assign raw_vec = {screen_end, down, up};

   // Only screen_end needs an edge detect; buttons are used as levels.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sync
         sync_edge #(.EDGE_EN(gi == 2)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (raw_vec[gi]),
            .sync  (sync_vec[gi]),
            .rise  (rise_vec[gi])
         );
      end
   endgenerate

   assign up_s       = sync_vec[0];
   assign down_s     = sync_vec[1];
   assign frame_tick = rise_vec[2];

   logic unused_sync;
   assign unused_sync = &{1'b0, sync_vec[2], rise_vec[1:0]};

   dino_state_t      state_reg;
   logic [Y_W-1:0]   y_reg;
   logic [V_W-1:0]   vel_reg;
   logic             airborne_reg;
   logic             ducking_reg;

   logic [Y_W-1:0]   rise_y;
   logic [V_W-1:0]   fall_v;
   logic [Y_W:0]     fall_y;
   logic             land;

   // One extra bit on the fall sum keeps the landing compare free of wrap.
   always_comb begin
      rise_y = ({4'd0, vel_reg} > y_reg) ? '0 : y_reg - {4'd0, vel_reg};
      fall_v = fall_speed(vel_reg);
      fall_y = {1'b0, y_reg} + {5'd0, fall_v};
      land   = (fall_y >= {1'b0, REST_Y});
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= RUN;
         y_reg        <= REST_Y;
         vel_reg      <= '0;
         airborne_reg <= 1'b0;
         ducking_reg  <= 1'b0;
      end else if (frame_tick && !freeze) begin
         case (state_reg)
            RUN: begin
               if (down_s) begin
                  state_reg   <= DUCK;
                  ducking_reg <= 1'b1;
               end else if (up_s) begin
                  state_reg    <= RISE;
                  vel_reg      <= 6'(JUMP_V);
                  airborne_reg <= 1'b1;
               end
            end
            RISE: begin
               if (down_s) begin
                  state_reg <= FALL;
                  vel_reg   <= '0;
               end else begin
                  y_reg <= rise_y;
                  if (vel_reg <= 6'(GRAVITY)) begin
                     state_reg <= FALL;
                     vel_reg   <= '0;
                  end else begin
                     vel_reg <= vel_reg - 6'(GRAVITY);
                  end
               end
            end
            FALL: begin
               if (land) begin
                  state_reg    <= RUN;
                  y_reg        <= REST_Y;
                  vel_reg      <= '0;
                  airborne_reg <= 1'b0;
               end else begin
                  y_reg   <= fall_y[Y_W-1:0];
                  vel_reg <= fall_v;
               end
            end
            DUCK: begin
               y_reg <= REST_Y;
               if (!down_s) begin
                  state_reg   <= RUN;
                  ducking_reg <= 1'b0;
               end
            end
            default: begin
               state_reg    <= RUN;
               y_reg        <= REST_Y;
               vel_reg      <= '0;
               airborne_reg <= 1'b0;
               ducking_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign dino_x   = 32'(DINO_X);
   assign dino_y   = {22'd0, y_reg};
   assign airborne = airborne_reg;
   assign ducking  = ducking_reg;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Frame-by-frame bench: each driven frame pushes the expected position/flags,
// which are popped and compared the clock after the DUT's frame_tick.
module tb_dino_motion_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        screen_end;
   logic        up;
   logic        down;
   logic        freeze;
   logic        frame_tick;
   logic [31:0] dino_x;
   logic [31:0] dino_y;
   logic        airborne;
   logic        ducking;

   always #5 clk = ~clk;

   dino_motion_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .screen_end (screen_end),
      .up         (up),
      .down       (down),
      .freeze     (freeze),
      .frame_tick (frame_tick),
      .dino_x     (dino_x),
      .dino_y     (dino_y),
      .airborne   (airborne),
      .ducking    (ducking)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int tick_cnt = 0;
   bit mon_en   = 1'b0;

   typedef struct packed {
      logic [31:0] y;
      logic        air;
      logic        duck;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: 0=RUN 1=RISE 2=FALL 3=DUCK
   int m_state;
   int m_y;
   int m_vel;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      m_state = 0;
      m_y     = 275;
      m_vel   = 0;
   endtask

   task automatic model_step(input bit u, input bit d, input bit frz);
      int v;
      int ny;
      if (frz) return;
      case (m_state)
         0: begin
            if (d) m_state = 3;
            else if (u) begin m_state = 1; m_vel = 12; end
         end
         1: begin
            if (d) begin m_state = 2; m_vel = 0; end
            else begin
               m_y = (m_y - m_vel < 0) ? 0 : m_y - m_vel;
               if (m_vel <= 1) begin m_state = 2; m_vel = 0; end
               else m_vel = m_vel - 1;
            end
         end
         2: begin
            v  = (m_vel + 1 > 12) ? 12 : m_vel + 1;
            ny = m_y + v;
            if (ny >= 275) begin m_y = 275; m_vel = 0; m_state = 0; end
            else begin m_y = ny; m_vel = v; end
         end
         default: begin
            m_y = 275;
            if (!d) m_state = 0;
         end
      endcase
   endtask

   // Buttons settle for 3 clocks before the 4-clock screen_end pulse.
   task automatic do_frame(input bit u, input bit d, input bit frz);
      int   t0;
      exp_t e;
      up     = u;
      down   = d;
      freeze = frz;
      repeat (3) @(negedge clk);
      model_step(u, d, frz);
      e.y    = m_y;
      e.air  = (m_state == 1 || m_state == 2);
      e.duck = (m_state == 3);
      exp_q.push_back(e);
      t0 = tick_cnt;
      screen_end = 1'b1;
      repeat (4) @(negedge clk);
      screen_end = 1'b0;
      repeat (4) @(negedge clk);
      check("tick_per_pulse", tick_cnt - t0, 1);
   endtask

   task automatic run_to_land();
      for (int k = 0; k < 40 && m_state != 0; k++) do_frame(1'b0, 1'b0, 1'b0);
      check("land_air", {31'd0, airborne}, 0);
      check("land_y", dino_y, 275);
   endtask

   initial begin : monitor
      logic        last_tick;
      logic [31:0] last_y;
      exp_t        e;
      last_tick = 1'b0;
      last_y    = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (last_tick) begin
               if (exp_q.size() == 0) begin
                  check("sb_underflow", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_y", dino_y, e.y);
                  check("sb_airborne", {31'd0, airborne}, {31'd0, e.air});
                  check("sb_ducking", {31'd0, ducking}, {31'd0, e.duck});
               end
            end else begin
               check("y_stable", dino_y, last_y);
            end
            if (frame_tick) tick_cnt++;
         end
         last_tick = frame_tick;
         last_y    = dino_y;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      reset      = 1'b1;
      screen_end = 1'b0;
      up         = 1'b0;
      down       = 1'b0;
      freeze     = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_y", dino_y, 275);
      check("rst_x", dino_x, 40);
      check("rst_air", {31'd0, airborne}, 0);
      check("rst_duck", {31'd0, ducking}, 0);
      check("rst_tick", {31'd0, frame_tick}, 0);
      reset = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      // Full jump from rest: entry, 12 rise, 12 fall.
      do_frame(1'b1, 1'b0, 1'b0);
      check("jump_entry_y", dino_y, 275);
      check("jump_entry_air", {31'd0, airborne}, 1);
      do_frame(1'b0, 1'b0, 1'b0);
      check("jump_first_rise", dino_y, 263);
      for (int k = 0; k < 11; k++) do_frame(1'b0, 1'b0, 1'b0);
      check("jump_apex", dino_y, 197);
      do_frame(1'b0, 1'b0, 1'b0);
      check("jump_first_fall", dino_y, 198);
      for (int k = 0; k < 10; k++) do_frame(1'b0, 1'b0, 1'b0);
      check("jump_pre_land_air", {31'd0, airborne}, 1);
      do_frame(1'b0, 1'b0, 1'b0);
      check("jump_25th_air", {31'd0, airborne}, 0);
      check("jump_25th_y", dino_y, 275);

      // Fast fall from y=233 during RISE.
      do_frame(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) do_frame(1'b0, 1'b0, 1'b0);
      check("ff_pre", dino_y, 233);
      do_frame(1'b0, 1'b1, 1'b0);
      check("ff_hold", dino_y, 233);
      check("ff_air", {31'd0, airborne}, 1);
      do_frame(1'b0, 1'b0, 1'b0);
      check("ff_y1", dino_y, 234);
      do_frame(1'b0, 1'b0, 1'b0);
      check("ff_y2", dino_y, 236);
      run_to_land();

      // up+down in RUN ducks; release down, then up starts a jump.
      do_frame(1'b1, 1'b1, 1'b0);
      check("duck_flag", {31'd0, ducking}, 1);
      check("duck_y", dino_y, 275);
      do_frame(1'b1, 1'b0, 1'b0);
      check("unduck_flag", {31'd0, ducking}, 0);
      check("unduck_air", {31'd0, airborne}, 0);
      do_frame(1'b1, 1'b0, 1'b0);
      check("duck_jump_air", {31'd0, airborne}, 1);

      // Held up re-triggers right after landing.
      for (int k = 0; k < 23; k++) do_frame(1'b1, 1'b0, 1'b0);
      do_frame(1'b1, 1'b0, 1'b0);
      check("held_land_air", {31'd0, airborne}, 0);
      check("held_land_y", dino_y, 275);
      do_frame(1'b1, 1'b0, 1'b0);
      check("auto_repeat_air", {31'd0, airborne}, 1);
      run_to_land();

      // Freeze for 10 frames at y=225 during RISE.
      do_frame(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) do_frame(1'b0, 1'b0, 1'b0);
      check("frz_pre", dino_y, 225);
      for (int k = 0; k < 10; k++) do_frame(1'b0, 1'b0, 1'b1);
      check("frz_y", dino_y, 225);
      check("frz_air", {31'd0, airborne}, 1);
      do_frame(1'b0, 1'b0, 1'b0);
      check("frz_resume", dino_y, 218);
      run_to_land();

      // Asynchronous reset while falling.
      do_frame(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 15; k++) do_frame(1'b0, 1'b0, 1'b0);
      check("mid_fall_y", dino_y, 203);
      mon_en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async_rst_y", dino_y, 275);
      check("async_rst_air", {31'd0, airborne}, 0);
      check("async_rst_duck", {31'd0, ducking}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      exp_q.delete();
      @(negedge clk);
      mon_en = 1'b1;
      do_frame(1'b1, 1'b0, 1'b0);
      check("post_rst_jump", {31'd0, airborne}, 1);
      run_to_land();

      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
